// File: rtl/booth_r4_mul_pipe_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: digit/stage counts and
// the digit-select encoding produced by the Booth recoder.
package booth_r4_mul_pipe_pkg;

  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_P1   = 3'd1,
    BOOTH_P2   = 3'd2,
    BOOTH_M1   = 3'd3,
    BOOTH_M2   = 3'd4
  } booth_sel_e;

  // One extra digit beyond WIDTH/2 so an unsigned multiplier's top bit is
  // never read as a sign.
  function automatic int booth_ndig(input int width);
    return width / 32'sd2 + 32'sd1;
  endfunction

  function automatic int booth_nstg(input int width, input int dps);
    return (booth_ndig(width) + dps - 32'sd1) / dps;
  endfunction

  function automatic booth_sel_e booth_sel(input logic [2:0] win);
    booth_sel_e sel;
    case (win)
      3'b001, 3'b010: sel = BOOTH_P1;
      3'b011:         sel = BOOTH_P2;
      3'b100:         sel = BOOTH_M2;
      3'b101, 3'b110: sel = BOOTH_M1;
      default:        sel = BOOTH_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_r4_mul_pipe_if.sv
// Operand/product handshake bundle for booth_r4_mul_pipe.
// Tag signals exist only when BOOTH_MUL_TAG_EN is defined.
interface booth_r4_mul_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_prod;

`ifdef BOOTH_MUL_TAG_EN
  logic [TAG_W-1:0] in_tag;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_signed, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_prod, out_tag
  );
  modport slave (
    input  in_valid, in_signed, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_prod, out_tag
  );
`else
  logic [TAG_W-1:0] unused_tag;
  assign unused_tag = {TAG_W{1'b0}};

  modport master (
    output in_valid, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_prod
  );
  modport slave (
    input  in_valid, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out_prod
  );
`endif
endinterface

// File: rtl/booth_r4_mul_pipe_digit.sv
// One radix-4 Booth digit: recodes a 3-bit multiplier window and adds the
// selected multiple of the (already positioned) multiplicand to the accumulator.
module booth_r4_digit
  import booth_r4_mul_pipe_pkg::*;
#(
  parameter int AW = 34
) (
  input  logic [AW-1:0] i_acc,
  input  logic [AW-1:0] i_a,
  input  logic [2:0]    i_win,
  output logic [AW-1:0] o_acc
);
  booth_sel_e w_sel;

  assign w_sel = booth_sel(i_win);

  // Accumulate d*A for d in {-2,-1,0,+1,+2}
  always_comb begin
    o_acc = i_acc;
    case (w_sel)
      BOOTH_P1: o_acc = i_acc + i_a;
      BOOTH_P2: o_acc = i_acc + (i_a << 1);
      BOOTH_M1: o_acc = i_acc - i_a;
      BOOTH_M2: o_acc = i_acc - (i_a << 1);
      default:  o_acc = i_acc;
    endcase
  end
endmodule

// File: rtl/booth_r4_mul_pipe.sv
// Fully pipelined radix-4 Booth multiplier, one op per cycle, latency NSTG+1.
// Optional per-op tag chain enabled by defining BOOTH_MUL_TAG_EN.
module booth_r4_mul_pipe
  import booth_r4_mul_pipe_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DIG_PER_STG = 1,
  parameter int TAG_W       = 8
) (
  input logic                clk,
  input logic                rst_n,
  booth_r4_mul_pipe_if.slave bus
);
  localparam int NDIG = booth_ndig(WIDTH);
  localparam int NSTG = booth_nstg(WIDTH, DIG_PER_STG);
  localparam int AW   = 2 * WIDTH + 2;
  localparam int BW   = WIDTH + 3;

  logic          w_adv;
  logic          w_sa;
  logic          w_sb;
  logic          w_v   [0:NSTG];
  logic [AW-1:0] w_a   [0:NSTG];
  logic [BW-1:0] w_b   [0:NSTG];
  logic [AW-1:0] w_acc [0:NSTG];

  logic          r_v0;
  logic [AW-1:0] r_a0;
  logic [BW-1:0] r_b0;

  // The whole pipe freezes only while a finished product waits downstream.
  assign w_adv         = !(w_v[NSTG] && !bus.out_ready);
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = w_v[NSTG];
  assign bus.out_prod  = w_acc[NSTG][2*WIDTH-1:0];

  assign w_sa = bus.in_signed & bus.in_a[WIDTH-1];
  assign w_sb = bus.in_signed & bus.in_b[WIDTH-1];

  // Input stage: extend operands by the op's own signedness
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0 <= 1'b0;
      r_a0 <= {AW{1'b0}};
      r_b0 <= {BW{1'b0}};
    end else if (w_adv) begin
      r_v0 <= bus.in_valid;
      if (bus.in_valid) begin
        r_a0 <= {{(AW-WIDTH){w_sa}}, bus.in_a};
        r_b0 <= {{2{w_sb}}, bus.in_b, 1'b0};
      end
    end
  end

  assign w_v[0]   = r_v0;
  assign w_a[0]   = r_a0;
  assign w_b[0]   = r_b0;
  assign w_acc[0] = {AW{1'b0}};

  for (genvar s = 1; s <= NSTG; s++) begin : g_stg
    logic [AW-1:0] w_part [0:DIG_PER_STG];
    logic          r_v;
    logic [AW-1:0] r_a;
    logic [BW-1:0] r_b;
    logic [AW-1:0] r_acc;

    assign w_part[0] = w_acc[s-1];

    for (genvar j = 0; j < DIG_PER_STG; j++) begin : g_dig
      if ((s - 1) * DIG_PER_STG + j < NDIG) begin : g_on
        booth_r4_digit #(.AW(AW)) u_dig (
          .i_acc (w_part[j]),
          .i_a   (w_a[s-1] << (2 * j)),
          .i_win (w_b[s-1][2*j+2:2*j]),
          .o_acc (w_part[j+1])
        );
      end else begin : g_off
        assign w_part[j+1] = w_part[j];
      end
    end

    // Stage register: retire this stage's digits, realign A and B for the next
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v   <= 1'b0;
        r_a   <= {AW{1'b0}};
        r_b   <= {BW{1'b0}};
        r_acc <= {AW{1'b0}};
      end else if (w_adv) begin
        r_v   <= w_v[s-1];
        r_a   <= w_a[s-1] << (2 * DIG_PER_STG);
        r_b   <= w_b[s-1] >> (2 * DIG_PER_STG);
        r_acc <= w_part[DIG_PER_STG];
      end
    end

    assign w_v[s]   = r_v;
    assign w_a[s]   = r_a;
    assign w_b[s]   = r_b;
    assign w_acc[s] = r_acc;
  end

`ifdef BOOTH_MUL_TAG_EN
  logic [TAG_W-1:0] w_tag [0:NSTG];
  logic [TAG_W-1:0] r_tag0;

  // Tag capture alongside the operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag0 <= {TAG_W{1'b0}};
    end else if (w_adv && bus.in_valid) begin
      r_tag0 <= bus.in_tag;
    end
  end

  assign w_tag[0] = r_tag0;

  for (genvar t = 1; t <= NSTG; t++) begin : g_tag
    logic [TAG_W-1:0] r_tag;

    // Tag follows its op through the same stall/advance as the data
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_tag <= {TAG_W{1'b0}};
      end else if (w_adv) begin
        r_tag <= w_tag[t-1];
      end
    end

    assign w_tag[t] = r_tag;
  end

  assign bus.out_tag = w_tag[NSTG];
`else
  logic [TAG_W-1:0] w_unused_tag;
  assign w_unused_tag = {TAG_W{1'b0}};
`endif

endmodule

// File: tb/tb_booth_r4_mul_pipe.sv
// Scoreboard bench for booth_r4_mul_pipe at WIDTH=16 with DIG_PER_STG 1, 3 and 9.
module tb_booth_r4_mul_pipe;

  typedef struct packed {
    logic [31:0] prod;
    logic [7:0]  tag;
    logic [31:0] cyc;
  } sb_t;

  logic        clk;
  logic        rst_n;
  logic        drv_valid;
  logic        drv_signed;
  logic        drv_ready;
  logic        wide_en;
  logic        lat_chk;
  logic [15:0] drv_a;
  logic [15:0] drv_b;
  logic [7:0]  drv_tag;
  logic [31:0] drv_exp;
  logic [31:0] cyc = 32'd0;
  int          total = 0;
  int          bad = 0;

  logic        rdy [3];
  logic        ov  [3];
  logic [31:0] op  [3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic sg, input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] ps;
    logic [31:0]        pu;
    ps = $signed(a) * $signed(b);
    pu = {16'd0, a} * {16'd0, b};
    return sg ? ps : pu;
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g_cfg
    localparam int P   = (i == 0) ? 1 : ((i == 1) ? 3 : 9);
    localparam int LAT = (9 + P - 1) / P + 1;

    booth_r4_mul_pipe_if #(.WIDTH(16), .TAG_W(8)) bus ();
    sb_t q [$];
    sb_t e;

    assign bus.in_valid  = drv_valid && ((i == 0) || wide_en);
    assign bus.in_signed = drv_signed;
    assign bus.in_a      = drv_a;
    assign bus.in_b      = drv_b;
    assign bus.out_ready = (i == 0) ? drv_ready : 1'b1;
`ifdef BOOTH_MUL_TAG_EN
    assign bus.in_tag    = drv_tag;
`endif
    assign rdy[i] = bus.in_ready;
    assign ov[i]  = bus.out_valid;
    assign op[i]  = bus.out_prod;

    booth_r4_mul_pipe #(.WIDTH(16), .DIG_PER_STG(P), .TAG_W(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    // Monitor: pop on output handoff, push on input handoff (both sampled mid-cycle)
    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            chk($sformatf("spurious_out_dps%0d", P), {63'd0, bus.out_valid}, 64'd0);
          end else begin
            e = q.pop_front();
            chk($sformatf("prod_dps%0d", P), {32'd0, bus.out_prod}, {32'd0, e.prod});
            if (lat_chk) chk($sformatf("latency_dps%0d", P), {32'd0, cyc - e.cyc}, 64'(LAT));
`ifdef BOOTH_MUL_TAG_EN
            chk($sformatf("tag_dps%0d", P), {56'd0, bus.out_tag}, {56'd0, e.tag});
`endif
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          e.prod = drv_exp;
          e.tag  = drv_tag;
          e.cyc  = cyc;
          q.push_back(e);
        end
      end
    end
  end

  // Present one op and hold it until the main DUT accepts it
  task automatic drive(input logic sg, input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
    logic ok;
    ok         = 1'b0;
    drv_valid  = 1'b1;
    drv_signed = sg;
    drv_a      = a;
    drv_b      = b;
    drv_exp    = exp;
    drv_tag    = drv_tag + 8'd1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = rdy[0];
    end
    if (!ok) chk("accept_wait", {63'd0, rdy[0]}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drv_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] held;
  logic        rs;
  logic [15:0] ra;
  logic [15:0] rb;

  initial begin
    rst_n = 1'b0; drv_valid = 1'b0; drv_signed = 1'b0; drv_ready = 1'b1;
    drv_a = 16'd0; drv_b = 16'd0; drv_tag = 8'd0; drv_exp = 32'd0;
    wide_en = 1'b0; lat_chk = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", {63'd0, ov[0]}, 64'd0);
    chk("reset_out_prod", {32'd0, op[0]}, 64'd0);
    chk("reset_in_ready", {63'd0, rdy[0]}, 64'd1);
    @(posedge clk);
    #1;

    // Directed corner products, back to back
    drive(1'b1, 16'h8000, 16'h8000, 32'h4000_0000);
    drive(1'b1, 16'hFFFF, 16'h0001, 32'hFFFF_FFFF);
    drive(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    drive(1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001);
    drive(1'b0, 16'h1234, 16'h0010, 32'h0001_2340);
    drive(1'b1, 16'h7FFF, 16'h8000, 32'hC000_8000);
    drive(1'b0, 16'h8000, 16'h8000, 32'h4000_0000);
    drive(1'b1, 16'h0003, 16'hFFFD, 32'hFFFF_FFF7);
    drive(1'b0, 16'h0000, 16'hBEEF, 32'h0000_0000);
    idle(14);

    // Fill the pipe, then hold off the consumer for 5 cycles
    for (int i = 1; i <= 10; i++) drive(1'b0, 16'(i), 16'h0101, 32'(i * 257));
    drv_ready = 1'b0;
    drv_valid = 1'b1;
    @(negedge clk);
    held = op[0];
    chk("stall_head_value", {32'd0, held}, 64'd257);
    for (int k = 0; k < 5; k++) begin
      chk("stall_in_ready", {63'd0, rdy[0]}, 64'd0);
      chk("stall_out_valid", {63'd0, ov[0]}, 64'd1);
      chk("stall_out_prod", {32'd0, op[0]}, {32'd0, held});
      if (k < 4) @(negedge clk);
    end
    @(posedge clk);
    #1 drv_ready = 1'b1;
    drive(1'b0, 16'd11, 16'h0101, 32'd2827);
    idle(14);

    // Reset with six ops in flight: nothing may survive it
    for (int i = 0; i < 6; i++) drive(1'b1, 16'(i * 100 + 7), 16'hFF00, model(1'b1, 16'(i * 100 + 7), 16'hFF00));
    drv_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {63'd0, ov[0]}, 64'd0);
    chk("midreset_out_prod", {32'd0, op[0]}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("postreset_in_ready", {63'd0, rdy[0]}, 64'd1);
    @(posedge clk);
    #1;
    idle(14);

    // Random back-to-back ops into all three configurations
    wide_en = 1'b1;
    lat_chk = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = 16'($urandom);
      drive(rs, ra, rb, model(rs, ra, rb));
    end
    idle(14);
    lat_chk = 1'b0;
    wide_en = 1'b0;

    chk("drained_dps1", 64'(g_cfg[0].q.size()), 64'd0);
    chk("drained_dps3", 64'(g_cfg[1].q.size()), 64'd0);
    chk("drained_dps9", 64'(g_cfg[2].q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
